test_sequencer: RTL and testbench

//  Hardware scheduler for self-test slots (register, ram, program_counter, core, ...).

---
 rtl/test_sequencer_pkg.sv | 12 +
 rtl/test_sequencer_if.sv | 23 ++
 rtl/test_sequencer_watchdog_counter.sv | 18 +
 rtl/test_sequencer.sv | 83 ++++++++
 tb/tb_test_sequencer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/test_sequencer_pkg.sv
// test_sequencer_pkg: shared state encodings and width helper for the self-test sequencer
package test_sequencer_pkg;
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_START  = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT   = 3'd2;
  localparam logic [STATE_W-1:0] S_GAP    = 3'd3;
  localparam logic [STATE_W-1:0] S_FINISH = 3'd4;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/test_sequencer_if.sv
// test_sequencer_if: control/status bundle between the sequencer and its slot tests
interface test_sequencer_if import test_sequencer_pkg::*; #(parameter int NUM_TESTS = 4);
  localparam int IDX_W = idx_width(NUM_TESTS);
  logic                 run_in;
  logic [NUM_TESTS-1:0] test_enable;
  logic [NUM_TESTS-1:0] test_done;
  logic [NUM_TESTS-1:0] test_result;
  logic [NUM_TESTS-1:0] test_start;
  logic [IDX_W-1:0]     current_idx;
  logic                 busy;
  logic                 all_done;
  logic                 pass;
  logic [NUM_TESTS-1:0] fail_mask;
  logic [NUM_TESTS-1:0] timeout_mask;
  modport master (
    output run_in, test_enable, test_done, test_result,
    input  test_start, current_idx, busy, all_done, pass, fail_mask, timeout_mask
  );
  modport slave (
    input  run_in, test_enable, test_done, test_result,
    output test_start, current_idx, busy, all_done, pass, fail_mask, timeout_mask
  );
endinterface

// File: rtl/test_sequencer_watchdog_counter.sv
// test_sequencer_watchdog_counter: per-slot WAIT watchdog, saturating at TIMEOUT_CYCLES-1
module test_sequencer_watchdog_counter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CNT_W-1:0] count;
  assign expired = count == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (enable && !expired) count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/test_sequencer.sv
// test_sequencer: runs enabled self-test slots one at a time and collects fail/timeout results
module test_sequencer import test_sequencer_pkg::*; #(
  parameter int NUM_TESTS = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic reset,
  test_sequencer_if.slave bus
);
  localparam int IDX_W = idx_width(NUM_TESTS);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STATE_W-1:0]   state, state_n;
  logic [IDX_W-1:0]     idx_n;
  logic [NUM_TESTS-1:0] en, en_n, fail_n, to_n;
  logic [IDX_W:0]       hit;
  logic                 expired;
  // {found, index} of the lowest set bit of m at or above position from
  function automatic logic [IDX_W:0] next_slot(input logic [NUM_TESTS-1:0] m, input int from);
    next_slot = '0;
    for (int i = NUM_TESTS - 1; i >= 0; i--)
      if (m[i] && i >= from) next_slot = {1'b1, IDX_W'(i)};
  endfunction
  test_sequencer_watchdog_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_wdog (
    .clk(clk), .reset(reset), .clear(state == S_START), .enable(state == S_WAIT), .expired(expired)
  );
  always_comb begin
    state_n = state;
    idx_n = bus.current_idx;
    en_n = en;
    fail_n = bus.fail_mask;
    to_n = bus.timeout_mask;
    hit = '0;
    case (state)
      S_IDLE, S_FINISH: if (bus.run_in) begin
        en_n = bus.test_enable;
        fail_n = '0;
        to_n = '0;
        hit = next_slot(bus.test_enable, 0);
        state_n = hit[IDX_W] ? S_START : S_FINISH;
        idx_n = hit[IDX_W-1:0];
      end
      S_START: state_n = S_WAIT;
      S_WAIT: if (bus.test_done[bus.current_idx]) begin
        fail_n[bus.current_idx] = bus.test_result[bus.current_idx];
        state_n = S_GAP;
      end else if (expired) begin
        fail_n[bus.current_idx] = 1'b1;
        to_n[bus.current_idx] = 1'b1;
        state_n = S_GAP;
      end
      S_GAP: begin
        hit = next_slot(en, int'(bus.current_idx) + 1);
        state_n = hit[IDX_W] ? S_START : S_FINISH;
        idx_n = hit[IDX_W] ? hit[IDX_W-1:0] : bus.current_idx;
      end
      default: state_n = S_IDLE;
    endcase
  end
  // outputs are registered from next-state values so they line up with the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      en <= '0;
      bus.current_idx <= '0;
      bus.test_start <= '0;
      bus.busy <= 1'b0;
      bus.all_done <= 1'b0;
      bus.pass <= 1'b0;
      bus.fail_mask <= '0;
      bus.timeout_mask <= '0;
    end else begin
      state <= state_n;
      en <= en_n;
      bus.current_idx <= idx_n;
      bus.test_start <= (state_n == S_START || state_n == S_WAIT) ? NUM_TESTS'(1) << idx_n : '0;
      bus.busy <= state_n inside {S_START, S_WAIT, S_GAP};
      bus.all_done <= state_n == S_FINISH;
      bus.pass <= state_n == S_FINISH && ~|fail_n;
      bus.fail_mask <= fail_n;
      bus.timeout_mask <= to_n;
    end
  end
endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: table-driven and directed checks of test_sequencer with modelled slot tests
module tb_test_sequencer;
  localparam logic [7:0] NEVER = 8'hFF;
  typedef struct packed {
    logic [3:0]      en;
    logic [3:0][7:0] dly;
    logic [3:0]      res;
    logic [3:0]      ef;
    logic [3:0]      et;
    logic            ep;
    logic [15:0]     eord;
    logic [3:0]      nord;
    logic [3:0][7:0] elen;
  } vec_t;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  test_sequencer_if #(.NUM_TESTS(4)) bus();
  test_sequencer #(.NUM_TESTS(4), .TIMEOUT_CYCLES(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  logic [3:0][7:0] cfg_dly, age, len;
  logic [3:0] cfg_res, prev;
  logic [15:0] ord;
  int n_ord, n_multi;
  int n_chk = 0, n_fail = 0;
  vec_t vec [6];
  // slot model: done rises once its start has been high for dly cycles; dly 0 = done stuck high
  initial forever @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.test_start[i]) len[i] = len[i] + 8'd1;
      if (bus.test_start[i] && !prev[i]) begin
        ord = {ord[11:0], 4'(i)};
        n_ord++;
      end
      age[i] = bus.test_start[i] ? age[i] + 8'd1 : 8'd0;
      bus.test_done[i] = cfg_dly[i] == 8'd0 ||
                         (bus.test_start[i] && cfg_dly[i] != NEVER && age[i] >= cfg_dly[i]);
    end
    if ($countones(bus.test_start) > 1) n_multi++;
    prev = bus.test_start;
    bus.test_result = cfg_res;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic start_run(input logic [3:0] en);
    ord = '0;
    n_ord = 0;
    len = '0;
    n_multi = 0;
    bus.test_enable = en;
    bus.run_in = 1'b1;
    @(negedge clk);
    bus.run_in = 1'b0;
    bus.test_enable = ~en;
  endtask
  task automatic wait_done(input string nm);
    int c = 0;
    while (!bus.all_done && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk({nm, " finish"}, 32'(bus.all_done), 32'd1);
  endtask
  initial begin
    bus.run_in = 0;
    bus.test_enable = '0;
    bus.test_done = '0;
    bus.test_result = '0;
    cfg_dly = {4{8'd5}};
    cfg_res = '0;
    age = '0;
    len = '0;
    prev = '0;
    ord = '0;
    n_ord = 0;
    n_multi = 0;
    vec[0] = '{en:4'hF, dly:{4{8'd5}}, res:4'h0, ef:4'h0, et:4'h0, ep:1'b1,
               eord:16'h0123, nord:4'd4, elen:{4{8'd5}}};
    vec[1] = '{en:4'hF, dly:{4{8'd5}}, res:4'b0100, ef:4'b0100, et:4'h0, ep:1'b0,
               eord:16'h0123, nord:4'd4, elen:{4{8'd5}}};
    vec[2] = '{en:4'hF, dly:{8'd5, 8'd5, NEVER, 8'd5}, res:4'h0, ef:4'b0010, et:4'b0010, ep:1'b0,
               eord:16'h0123, nord:4'd4, elen:{8'd5, 8'd5, 8'd17, 8'd5}};
    vec[3] = '{en:4'b1001, dly:{4{8'd5}}, res:4'h0, ef:4'h0, et:4'h0, ep:1'b1,
               eord:16'h0003, nord:4'd2, elen:{8'd5, 8'd0, 8'd0, 8'd5}};
    vec[4] = '{en:4'hF, dly:{8'd5, 8'd17, 8'd18, 8'd17}, res:4'b0100, ef:4'b0110, et:4'b0010, ep:1'b0,
               eord:16'h0123, nord:4'd4, elen:{8'd5, 8'd17, 8'd17, 8'd17}};
    vec[5] = '{en:4'hF, dly:{4{8'd0}}, res:4'b1000, ef:4'b1000, et:4'h0, ep:1'b0,
               eord:16'h0123, nord:4'd4, elen:{4{8'd2}}};
    repeat (3) @(negedge clk);
    chk("rst start", 32'(bus.test_start), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst all_done", 32'(bus.all_done), 32'd0);
    chk("rst pass", 32'(bus.pass), 32'd0);
    chk("rst fail", 32'(bus.fail_mask), 32'd0);
    chk("rst timeout", 32'(bus.timeout_mask), 32'd0);
    chk("rst idx", 32'(bus.current_idx), 32'd0);
    reset = 0;
    @(negedge clk);
    start_run(4'h0);
    chk("empty all_done", 32'(bus.all_done), 32'd1);
    chk("empty pass", 32'(bus.pass), 32'd1);
    chk("empty busy", 32'(bus.busy), 32'd0);
    chk("empty start", 32'(bus.test_start), 32'd0);
    for (int k = 0; k < 6; k++) begin
      string nm;
      nm = $sformatf("vec%0d", k);
      cfg_dly = vec[k].dly;
      cfg_res = vec[k].res;
      @(negedge clk);
      start_run(vec[k].en);
      chk({nm, " first start"}, 32'(bus.test_start), 32'(vec[k].en & (~vec[k].en + 4'd1)));
      wait_done(nm);
      chk({nm, " fail"}, 32'(bus.fail_mask), 32'(vec[k].ef));
      chk({nm, " timeout"}, 32'(bus.timeout_mask), 32'(vec[k].et));
      chk({nm, " pass"}, 32'(bus.pass), 32'(vec[k].ep));
      chk({nm, " busy"}, 32'(bus.busy), 32'd0);
      chk({nm, " order"}, 32'(ord), 32'(vec[k].eord));
      chk({nm, " starts"}, 32'(n_ord), 32'(vec[k].nord));
      chk({nm, " lengths"}, 32'(len), 32'(vec[k].elen));
      chk({nm, " onehot"}, 32'(n_multi), 32'd0);
    end
    cfg_dly = {4{8'd5}};
    cfg_res = '0;
    @(negedge clk);
    start_run(4'hF);
    repeat (2) @(negedge clk);
    chk("busy in wait", 32'(bus.busy), 32'd1);
    bus.run_in = 1'b1;
    bus.test_enable = 4'h0;
    @(negedge clk);
    bus.run_in = 1'b0;
    chk("run ignored start", 32'(bus.test_start), 32'd1);
    wait_done("run ignored");
    chk("run ignored pass", 32'(bus.pass), 32'd1);
    chk("run ignored order", 32'(ord), 32'h0123);
    chk("run ignored starts", 32'(n_ord), 32'd4);
    cfg_res = 4'b0010;
    start_run(4'hF);
    begin
      int c = 0;
      while (bus.test_start !== 4'b0100 && c < 100) begin
        @(negedge clk);
        c++;
      end
    end
    chk("reach slot2", 32'(bus.test_start), 32'b0100);
    @(negedge clk);
    chk("pre-reset fail", 32'(bus.fail_mask), 32'b0010);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort start", 32'(bus.test_start), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort fail", 32'(bus.fail_mask), 32'd0);
    chk("abort timeout", 32'(bus.timeout_mask), 32'd0);
    chk("abort all_done", 32'(bus.all_done), 32'd0);
    cfg_res = '0;
    @(negedge clk);
    start_run(4'hF);
    wait_done("rerun");
    chk("rerun pass", 32'(bus.pass), 32'd1);
    chk("rerun fail", 32'(bus.fail_mask), 32'd0);
    chk("rerun order", 32'(ord), 32'h0123);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
